// File: rtl/fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch_buffer
//  Description : Instruction prefetch FIFO. Keeps at most one instruction
//                memory request in flight, fills a DEPTH-entry buffer of
//                {instr, pc} pairs and hands the head to decode. A redirect
//                flushes the buffer and discards any response still owed to
//                the old stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt_sys,
    input  logic                   redirect_en,
    input  logic [15:0]            redirect_addr,
    output logic                   imem_req,
    output logic [15:0]            imem_addr,
    input  logic                   imem_rvalid,
    input  logic [15:0]            imem_rdata,
    output logic                   out_valid,
    output logic [15:0]            out_instr,
    output logic [15:0]            out_pc,
    input  logic                   in_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_fetch_pc;
    logic [15:0]       r_req_pc;
    logic [c_AW-1:0]   r_head;
    logic [c_AW-1:0]   r_tail;
    logic [c_CW-1:0]   r_count;
    logic [15:0]       r_mem_instr [DEPTH];
    logic [15:0]       r_mem_pc    [DEPTH];

    logic              w_busy;
    logic [c_CW-1:0]   w_occ;
    logic              w_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;

    // An outstanding request reserves a slot, so credit counts it as occupied.
    // Only registered values are used: a pop this cycle frees nothing yet.
    assign w_busy   = (r_state != S_IDLE);
    assign w_occ    = r_count + {{c_AW{1'b0}}, w_busy};
    assign w_credit = (w_occ < c_DEPTH);

    assign w_issue  = w_credit && !halt_sys && !redirect_en &&
                      ((r_state == S_IDLE) || ((r_state == S_WAIT) && imem_rvalid));
    assign w_push   = (r_state == S_WAIT) && imem_rvalid && !redirect_en;
    assign w_pop    = (r_count != '0) && in_ready && !halt_sys && !redirect_en;

    // Request is masked while reset is held so nothing escapes during reset.
    assign imem_req  = w_issue && rst;
    assign imem_addr = r_fetch_pc;

    assign out_valid = (r_count != '0);
    assign out_instr = r_mem_instr[r_head];
    assign out_pc    = r_mem_pc[r_head];
    assign count     = r_count;

    // Request-tracking state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: WAIT keeps the response, DROP throws it away.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_en) begin
                    w_state_nxt = imem_rvalid ? S_IDLE : S_DROP;
                end else if (imem_rvalid) begin
                    w_state_nxt = w_issue ? S_WAIT : S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Fetch address, pc of the in-flight request, and FIFO pointers/occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= 16'h0000;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect_en) begin
            r_fetch_pc <= redirect_addr & 16'hFFFE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 16'd2;
                r_req_pc   <= r_fetch_pc;
            end
            if (w_push) begin
                r_tail <= r_tail + c_AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_tail] <= imem_rdata;
            r_mem_pc[r_tail]    <= r_req_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_prefetch_buffer
//  Description : Directed self-checking bench for fetch_prefetch_buffer with a
//                fixed-latency single-outstanding instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_sys = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        in_ready = 1'b0;
    logic [2:0]  count;

    int n_total = 0;
    int n_bad   = 0;

    // Memory model state
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = 16'h0000;
    int          mem_lat = 1;
    bit          last_req = 1'b0;
    logic [15:0] last_addr = 16'h0000;

    fetch_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .halt_sys      (halt_sys),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .in_ready      (in_ready),
        .count         (count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the response due this cycle, record any request,
    // cross the rising edge, then age the outstanding request.
    task automatic cycle();
        bit delivered;
        delivered   = pend && (pend_cnt == 1);
        imem_rvalid = delivered;
        imem_rdata  = delivered ? mem_word(pend_addr) : 16'h0000;
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        @(posedge clk);
        #1;
        if (delivered) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (last_req) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_addr = last_addr;
        end
        imem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        pend        = 1'b0;
        halt_sys    = 1'b0;
        redirect_en = 1'b0;
        imem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_req(input logic [15:0] a, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            cycle();
            if (last_req && last_addr == a) hit = 1'b1;
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nreq;
        // Reset values, held without any clock edge
        #1 rst = 1'b0;
        #2;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming with 1-cycle memory
        mem_lat  = 1;
        in_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("s1_req", {31'd0, last_req}, 32'd1);
            chk("s1_addr", {16'd0, last_addr}, 2 * i);
            if (i >= 1) begin
                chk("s1_valid", {31'd0, out_valid}, 32'd1);
                chk("s1_pc", {16'd0, out_pc}, 2 * (i - 1));
                chk("s1_instr", {16'd0, out_instr}, {16'd0, mem_word(16'(2 * (i - 1)))});
            end
        end
        chk("s1_count", {29'd0, count}, 32'd1);

        // Decode stalled: fill to DEPTH, then a pop reopens credit
        do_reset();
        in_ready = 1'b0;
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_req) nreq++;
        end
        chk("s2_nreq", nreq, 32'd4);
        chk("s2_count", {29'd0, count}, 32'd4);
        chk("s2_head", {16'd0, out_pc}, 32'h0000);
        in_ready = 1'b1;
        cycle();
        chk("s2_pop_noreq", {31'd0, last_req}, 32'd0);
        chk("s2_pop_count", {29'd0, count}, 32'd3);
        cycle();
        chk("s2_req", {31'd0, last_req}, 32'd1);
        chk("s2_addr", {16'd0, last_addr}, 32'h0008);
        in_ready = 1'b0;

        // 3-cycle memory, redirect while 0x0004 is outstanding
        do_reset();
        mem_lat = 3;
        wait_req(16'h0004, 20, "s3_reach4");
        redirect_en   = 1'b1;
        redirect_addr = 16'h0041;
        cycle();
        redirect_en = 1'b0;
        chk("s3_flush_count", {29'd0, count}, 32'd0);
        chk("s3_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("s3_redir_noreq", {31'd0, last_req}, 32'd0);
        cycle();
        chk("s3_drop_noreq1", {31'd0, last_req}, 32'd0);
        cycle();
        chk("s3_drop_noreq2", {31'd0, last_req}, 32'd0);
        chk("s3_drop_count", {29'd0, count}, 32'd0);
        cycle();
        chk("s3_req", {31'd0, last_req}, 32'd1);
        chk("s3_addr", {16'd0, last_addr}, 32'h0040);
        repeat (3) cycle();
        chk("s3_valid", {31'd0, out_valid}, 32'd1);
        chk("s3_pc", {16'd0, out_pc}, 32'h0040);
        chk("s3_instr", {16'd0, out_instr}, {16'd0, mem_word(16'h0040)});

        // Redirect coinciding with the response
        do_reset();
        mem_lat = 1;
        cycle();
        chk("s4_req0", {16'd0, last_addr}, 32'h0000);
        redirect_en   = 1'b1;
        redirect_addr = 16'h1235;
        cycle();
        redirect_en = 1'b0;
        chk("s4_noreq", {31'd0, last_req}, 32'd0);
        chk("s4_count", {29'd0, count}, 32'd0);
        cycle();
        chk("s4_req", {31'd0, last_req}, 32'd1);
        chk("s4_addr", {16'd0, last_addr}, 32'h1234);

        // Halt while a request is outstanding
        in_ready = 1'b1;
        halt_sys = 1'b1;
        cycle();
        chk("s5_noreq", {31'd0, last_req}, 32'd0);
        chk("s5_count", {29'd0, count}, 32'd1);
        chk("s5_pc", {16'd0, out_pc}, 32'h1234);
        cycle();
        cycle();
        chk("s5_hold_noreq", {31'd0, last_req}, 32'd0);
        chk("s5_hold_count", {29'd0, count}, 32'd1);
        halt_sys = 1'b0;
        cycle();
        chk("s5_req", {31'd0, last_req}, 32'd1);
        chk("s5_addr", {16'd0, last_addr}, 32'h1236);
        chk("s5_pop_count", {29'd0, count}, 32'd0);

        // Address wrap, then reset asserted mid-request
        in_ready      = 1'b0;
        redirect_en   = 1'b1;
        redirect_addr = 16'hFFFE;
        cycle();
        redirect_en = 1'b0;
        cycle();
        chk("s6_addr_ffff", {16'd0, last_addr}, 32'hFFFE);
        cycle();
        chk("s6_wrap_req", {31'd0, last_req}, 32'd1);
        chk("s6_wrap_addr", {16'd0, last_addr}, 32'h0000);
        cycle();
        chk("s6_count", {29'd0, count}, 32'd2);
        rst  = 1'b0;
        pend = 1'b0;
        #1;
        chk("s6_async_count", {29'd0, count}, 32'd0);
        chk("s6_async_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_async_req", {31'd0, imem_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
        chk("s6_rel_req", {31'd0, last_req}, 32'd1);
        chk("s6_rel_addr", {16'd0, last_addr}, 32'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_buffer.md
FETCH_PREFETCH_BUFFER -- requirements
Module: fetch_prefetch_buffer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DEPTH, 4, FIFO entries (power of two, at least 2); RESET_PC, 16'h0000, first fetch address after reset.
REQ-002 The block SHALL have this port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have this port: rst  in  1  reset; asynchronous and active-low (one clock; reset is asynchronous and active-low).
REQ-004 The block SHALL have this port: halt_sys  in  1  freezes issue and pop while high.
REQ-005 The block SHALL have this port: redirect_en  in  1  jump/branch taken; flushes the buffer.
REQ-006 The block SHALL have this port: redirect_addr  in  16  new fetch byte address; bit 0 is ignored and treated as 0.
REQ-007 The block SHALL have this port: imem_req  out  1  single-cycle request pulse; memory accepts it unconditionally.
REQ-008 The block SHALL have this port: imem_addr  out  16  request address; valid only while imem_req is high.
REQ-009 The block SHALL have this port: imem_rvalid  in  1  response strobe, in order, arriving 1 or more cycles after its request.
REQ-010 The block SHALL have this port: imem_rdata  in  16  response instruction word.
REQ-011 The block SHALL have this port: out_valid  out  1  head entry available to decode.
REQ-012 The block SHALL have this port: out_instr  out  16  head instruction.
REQ-013 The block SHALL have this port: out_pc  out  16  byte address of the head instruction.
REQ-014 The block SHALL have this port: in_ready  in  1  decode accepts the head this cycle (low means a hazard stall).
REQ-015 The block SHALL have this port: count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 The block SHALL keep at most one outstanding memory request, tracked by a state machine with states IDLE (none outstanding), WAIT (outstanding, keep the response) and DROP (outstanding, discard the response).
REQ-017 Credit rule: credit SHALL be true when count + (state != IDLE ? 1 : 0) < DEPTH, using registered values; a pop in the same cycle SHALL NOT add credit.
REQ-018 Issue rule: the block SHALL issue (imem_req=1, imem_addr=fetch_pc) when credit && !halt_sys && !redirect_en && (state==IDLE || (state==WAIT && imem_rvalid)); fetch_pc SHALL then advance by 2, wrapping 16'hFFFE to 16'h0000.
REQ-019 WAIT and imem_rvalid: the block SHALL push {imem_rdata, pc of that request} to the tail; it SHALL go to WAIT if it issued this cycle, otherwise to IDLE.
REQ-020 Redirect: when redirect_en is high, the FIFO SHALL be emptied (count=0); fetch_pc SHALL become {redirect_addr[15:1],1'b0}; no issue or push SHALL occur that cycle.
REQ-021 Redirect state transitions: IDLE SHALL go to IDLE; WAIT without rvalid SHALL go to DROP; WAIT with rvalid SHALL go to IDLE and discard the data; DROP without rvalid SHALL stay in DROP; DROP with rvalid SHALL go to IDLE.
REQ-022 DROP and imem_rvalid without redirect: the block SHALL discard the data and go to IDLE; the first new request SHALL issue on the next cycle at the earliest.
REQ-023 out_valid SHALL equal (count != 0); out_instr and out_pc SHALL be driven from registered FIFO storage at the head with no combinational path from imem_rdata.
REQ-024 Pop: a pop SHALL occur when out_valid && in_ready && !halt_sys && !redirect_en; the head pointer SHALL advance modulo DEPTH.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push never targets a full FIFO because of the credit rule.
REQ-026 halt_sys SHALL block issue and pop only; a response to an already outstanding request SHALL still be pushed (WAIT) or dropped (DROP); redirect SHALL still act during halt.
REQ-027 Throughput: with 1-cycle memory latency, in_ready held high and no redirect, the block SHALL sustain one instruction per cycle after the initial fill.

Reset
REQ-028 While rst=0, the block SHALL set state=IDLE, fetch_pc=RESET_PC, count=0, head/tail pointers=0, out_valid=0 and imem_req=0, asynchronously and regardless of clk.
REQ-029 A response arriving after reset release that belongs to a request issued before reset SHALL be treated as DROP; the block SHALL enter DROP on reset release only if the bench asserted reset mid-request, and the memory model SHALL not deliver such a response.
REQ-030 The first request after reset release SHALL be issued on the first rising clk edge with rst=1, at imem_addr=RESET_PC.

Verification
REQ-031 Bench scenario: reset release, 1-cycle memory, in_ready=1 -> requests at 0x0000, 0x0002, 0x0004...; out_pc sequence 0x0000, 0x0002...; one instruction per cycle from the third cycle.
REQ-032 Bench scenario: in_ready=0 with DEPTH=4 -> exactly 4 requests issued; count=4; imem_req stays 0; after in_ready=1, one pop reopens credit and the next request is at 0x0008.
REQ-033 Bench scenario: 3-cycle memory latency, redirect_addr=0x0041 asserted in the cycle after the request at 0x0004 -> the 0x0004 response is discarded (DROP); count=0; next request at 0x0040; next out_pc=0x0040.
REQ-034 Bench scenario: redirect in the same cycle as imem_rvalid -> the data is not pushed; state=IDLE; the request to the redirect address is issued the following cycle.
REQ-035 Bench scenario: halt_sys=1 while WAIT -> the response is pushed; count increments by 1; no further imem_req and no pop until halt_sys=0.
REQ-036 Bench scenario: fetch_pc=0xFFFE -> the next request after 0xFFFE is at 0x0000; rst asserted mid-WAIT -> all outputs return to reset values immediately, without a clock edge.
